vga_sync_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 50 MHz master clock: hsync, vsync, pixel coordinates, a visible-area flag and a pixel strobe.
- Uses an internal pixel clock-enable and runs entirely on one clock; it never produces a derived clock.
- Sits between the master clock and the sudoku pixel renderer. The renderer registers its colour output using pix_en and uses x/y to choose what to draw.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_axis_timer.sv | 51 +++++
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, the per-axis phase type and the count-to-phase decode
// used by both the horizontal and vertical axis timers.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_e;

  // Phase of one axis for a given count; everything past the sync window is back porch.
  function automatic axis_state_e axis_state(input logic [COORD_W-1:0] cnt,
                                             input int unsigned        vis,
                                             input int unsigned        fp,
                                             input int unsigned        sync_len);
    axis_state_e st;
    if (cnt < COORD_W'(vis))                       st = ACTIVE;
    else if (cnt < COORD_W'(vis + fp))             st = FRONT;
    else if (cnt < COORD_W'(vis + fp + sync_len))  st = SYNC;
    else                                           st = BACK;
    return st;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One VGA axis: a wrapping position counter plus sync/visible decode of its next count,
// so the parent can register flags that line up with the counter.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned VIS_LEN  = DEF_H_VIS,
  parameter int unsigned FP_LEN   = DEF_H_FP,
  parameter int unsigned SYNC_LEN = DEF_H_SYNC,
  parameter int unsigned BP_LEN   = DEF_H_BP
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               step_i,
  output logic [COORD_W-1:0] count_o,
  output logic               sync_n_nxt_o,
  output logic               vis_nxt_o,
  output logic               wrap_o
);

  localparam int unsigned        TOTAL = VIS_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [COORD_W-1:0] LAST  = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] count_q, count_d;
  axis_state_e        state_d;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (step_i) begin
      if (count_q >= LAST) begin
        count_d = '0;
        wrap_o  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign state_d      = axis_state(count_d, VIS_LEN, FP_LEN, SYNC_LEN);
  assign sync_n_nxt_o = (state_d != SYNC);
  assign vis_nxt_o    = (state_d == ACTIVE);
  assign count_o      = count_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator on the master clock with a pixel clock-enable (no derived clock).
// Define FRAME_CNT_EN to add the 8-bit frame_cnt output for cursor-blink timing.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV = 2,
  parameter int unsigned H_VIS   = DEF_H_VIS,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_VIS   = DEF_V_VIS,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP
) (
  input  logic               clk,
  input  logic               clr,
  output logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
`ifdef FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             h_wrap, v_wrap;
  logic             h_sync_n_nxt, v_sync_n_nxt, h_vis_nxt, v_vis_nxt;
  logic             hsync_q, vsync_q, video_on_q, frame_start_q;

  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign pix_en = !clr && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) div_q <= '0;
    else     div_q <= div_d;
  end

  vga_axis_timer #(
    .VIS_LEN (H_VIS),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_h_timer (
    .clk         (clk),
    .clr         (clr),
    .step_i      (pix_en),
    .count_o     (x),
    .sync_n_nxt_o(h_sync_n_nxt),
    .vis_nxt_o   (h_vis_nxt),
    .wrap_o      (h_wrap)
  );

  // The vertical axis only moves on the pixel that ends a line.
  vga_axis_timer #(
    .VIS_LEN (V_VIS),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_v_timer (
    .clk         (clk),
    .clr         (clr),
    .step_i      (h_wrap),
    .count_o     (y),
    .sync_n_nxt_o(v_sync_n_nxt),
    .vis_nxt_o   (v_vis_nxt),
    .wrap_o      (v_wrap)
  );

  // Flags are decoded from the next counts so they change in the same clk as x/y.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= h_sync_n_nxt;
      vsync_q       <= v_sync_n_nxt;
      video_on_q    <= h_vis_nxt && v_vis_nxt;
      frame_start_q <= v_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

`ifdef FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)         frame_cnt_q <= '0;
    else if (v_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: four timing configurations run side by side against an arithmetic
// model of position versus elapsed clocks, plus line/frame-level measurements.
module tb_vga_sync_gen;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic       pe [NI];
  logic [9:0] xs [NI];
  logic [9:0] ys [NI];
  logic       hs [NI];
  logic       vs [NI];
  logic       vo [NI];
  logic       fs [NI];
  logic [7:0] fc [NI];
  logic [39:0] act_w [NI];

  // Configuration table: {PIX_DIV, H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP}
  function automatic int unsigned prm(input int k, input int i);
    bit [8:0][15:0] tab;
    case (k)
      0:       tab = {16'd2, 16'd640, 16'd16, 16'd96, 16'd48, 16'd480, 16'd10, 16'd2, 16'd33};
      1:       tab = {16'd1, 16'd640, 16'd16, 16'd96, 16'd48, 16'd480, 16'd10, 16'd2, 16'd33};
      2:       tab = {16'd2, 16'd8,   16'd2,  16'd3,  16'd2,  16'd6,   16'd2,  16'd2, 16'd2};
      default: tab = {16'd1, 16'd2,   16'd1,  16'd1,  16'd1,  16'd2,   16'd1,  16'd1, 16'd1};
    endcase
    return int'(tab[8 - i]);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_sync_gen #(
      .PIX_DIV(prm(g, 0)),
      .H_VIS  (prm(g, 1)),
      .H_FP   (prm(g, 2)),
      .H_SYNC (prm(g, 3)),
      .H_BP   (prm(g, 4)),
      .V_VIS  (prm(g, 5)),
      .V_FP   (prm(g, 6)),
      .V_SYNC (prm(g, 7)),
      .V_BP   (prm(g, 8))
    ) u_dut (
      .clk        (clk),
      .clr        (clr),
      .pix_en     (pe[g]),
      .x          (xs[g]),
      .y          (ys[g]),
      .hsync      (hs[g]),
      .vsync      (vs[g]),
      .video_on   (vo[g]),
      .frame_start(fs[g])
`ifdef FRAME_CNT_EN
      ,
      .frame_cnt  (fc[g])
`endif
    );
`ifndef FRAME_CNT_EN
    assign fc[g] = 8'd0;
`endif
    assign act_w[g] = {7'd0, fc[g], pe[g], xs[g], ys[g], hs[g], vs[g], vo[g], fs[g]};
  end

  localparam logic [39:0] RST_W = {7'd0, 8'd0, 1'b0, 10'd0, 10'd0, 4'b1110};

  // Expected outputs t clocks after reset release, derived from pixel index arithmetic.
  function automatic logic [39:0] model(input int k, input bit in_rst, input int t);
    int pd, hv, hf, hsw, vv, vf, vsw, ht, vt, p, pos, xx, yy, fcn;
    bit pe_e, hs_e, vs_e, vo_e, fs_e;
    if (in_rst) return RST_W;
    pd  = prm(k, 0);
    hv  = prm(k, 1); hf = prm(k, 2); hsw = prm(k, 3); ht = hv + hf + hsw + prm(k, 4);
    vv  = prm(k, 5); vf = prm(k, 6); vsw = prm(k, 7); vt = vv + vf + vsw + prm(k, 8);
    p    = t / pd;
    pe_e = ((t % pd) == pd - 1);
    pos  = p % (ht * vt);
    xx   = pos % ht;
    yy   = pos / ht;
    hs_e = !(xx >= hv + hf && xx < hv + hf + hsw);
    vs_e = !(yy >= vv + vf && yy < vv + vf + vsw);
    vo_e = (xx < hv) && (yy < vv);
    fs_e = (pos == 0) && (p > 0) && ((t % pd) == 0);
`ifdef FRAME_CNT_EN
    fcn = (p / (ht * vt)) % 256;
`else
    fcn = 0;
`endif
    return {7'd0, 8'(fcn), pe_e, 10'(xx), 10'(yy), hs_e, vs_e, vo_e, fs_e};
  endfunction

  typedef struct packed {
    int          k;
    logic [39:0] w;
  } exp_t;

  exp_t  exp_q[$];
  string names[NI] = '{"def", "div1", "sml", "tny"};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  int  t       = 0;
  int  cyc     = 0;
  bit  mon_en  = 1'b0;
  bit  hs_p0   = 1'b1, hs_p1 = 1'b1, vo_p0 = 1'b1;
  int  hfall0  = -1, hfall1 = -1, fs_last2 = -1, vis_cnt2 = 0, fs_n3 = 0;
  logic [9:0] x_p1 = '0, y_p1 = '0;

  task automatic monitor();
    if (mon_en) begin
      if (hs_p0 && !hs[0]) begin
        check("def_hs_fall_x", 40'(xs[0]), 40'd656);
        if (hfall0 >= 0) check("def_hs_period", 40'(cyc - hfall0), 40'd1600);
        hfall0 = cyc;
      end
      if (!hs_p0 && hs[0] && hfall0 >= 0) check("def_hs_low", 40'(cyc - hfall0), 40'd192);
      if (vo_p0 && !vo[0]) check("def_vo_drop_x", 40'(xs[0]), 40'd640);

      if (hs_p1 && !hs[1]) begin
        if (hfall1 >= 0) check("div1_hs_period", 40'(cyc - hfall1), 40'd800);
        hfall1 = cyc;
      end
      if (x_p1 == 10'd799) begin
        check("div1_x_wrap", 40'(xs[1]), 40'd0);
        check("div1_y_step", 40'(ys[1]), 40'(y_p1) + 40'd1);
      end

      if (fs[2]) begin
        check("sml_fs_xy", 40'({xs[2], ys[2]}), 40'd0);
        if (fs_last2 >= 0) begin
          check("sml_fs_period", 40'(cyc - fs_last2), 40'd360);
          check("sml_vis_pixels", 40'(vis_cnt2), 40'd48);
        end
        fs_last2 = cyc;
        vis_cnt2 = 0;
      end
      if (pe[2] && vo[2]) vis_cnt2++;

`ifdef FRAME_CNT_EN
      if (fs[3]) begin
        fs_n3++;
        if (fs_n3 == 3)   check("tny_fc_3", 40'(fc[3]), 40'd3);
        if (fs_n3 == 256) check("tny_fc_wrap", 40'(fc[3]), 40'd0);
      end
`endif
    end
    hs_p0 = hs[0];
    hs_p1 = hs[1];
    vo_p0 = vo[0];
    x_p1  = xs[1];
    y_p1  = ys[1];
  endtask

  // Drive clr for the next edge, queue what every instance must show after it, then compare.
  task automatic tick(input bit rst_v);
    exp_t e;
    clr = rst_v;
    if (rst_v) t = 0;
    else       t = t + 1;
    for (int k = 0; k < NI; k++) exp_q.push_back('{k: k, w: model(k, rst_v, t)});
    @(posedge clk);
    #1;
    cyc++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({names[e.k], "_sb"}, act_w[e.k], e.w);
    end
    monitor();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1);

    mon_en = 1'b1;
    for (int i = 0; i < 7000; i++) tick(1'b0);
    mon_en = 1'b0;

    // Small config sits at (5,5) here; the reset must clear it without waiting for a clock.
    check("sml_pre_rst_xy", 40'({xs[2], ys[2]}), 40'({10'd5, 10'd5}));
    clr = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) check({names[k], "_async_rst"}, act_w[k], RST_W);
    for (int i = 0; i < 3; i++) tick(1'b1);

    clr = 1'b0;
    #1;
    check("sml_rel_pe_low", 40'(pe[2]), 40'd0);
    check("div1_rel_pe_high", 40'(pe[1]), 40'd1);
    for (int i = 0; i < 1000; i++) tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
